taglist_writer: RTL and testbench

TAGLIST_WRITER -- requirements
Module: taglist_writer

---
 rtl/taglist_pkg.sv | 32 +++
 rtl/taglist_writer.sv | 159 +++++++++++++++
 tb/tb_taglist_writer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/taglist_pkg.sv
// -----------------------------------------------------------------------------
// taglist_pkg
//   Items shared by the tag-list writer and the ROM-side logic:
//     - bit positions and widths of the packed 32-bit tag-list entry
//     - the ROM word address width
//     - the writer FSM state encoding
//   Entry layout: [31:28] zero, [27:21] tag, [20:11] start, [10:1] end,
//   [0] last flag.
// -----------------------------------------------------------------------------
package taglist_pkg;

   localparam int ROM_AW    = 10;

   localparam int TAG_W     = 7;
   localparam int TAG_LSB   = 21;
   localparam int START_W   = ROM_AW;
   localparam int START_LSB = 11;
   localparam int END_W     = ROM_AW;
   localparam int END_LSB   = 1;
   localparam int LAST_BIT  = 0;

   localparam int ENTRY_W   = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READY = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

endpackage

// File: rtl/taglist_writer.sv
// -----------------------------------------------------------------------------
// taglist_writer
//   Turns a stream of segment descriptors (length-1, last) into packed
//   tag-list entries written one per WRITE cycle into a tag-list RAM.
//   Segments are laid out back to back in ROM word space starting at 0.
//
// Ports
//   clock_n      in   clock, all state on its rising edge
//   reset        in   asynchronous active-high reset
//   list_start   in   one-cycle pulse, (re)starts a list from any state
//   seg_valid    in   descriptor offered
//   seg_ready    out  descriptor accepted this cycle (READY only)
//   seg_len      in   segment length in ROM words minus 1
//   seg_last     in   final segment of the list
//   taglist_wr   out  RAM write enable (WRITE only)
//   taglist_addr out  RAM entry index
//   taglist_data out  packed entry
//   entry_count  out  entries written in the current list
//   done         out  list closed with its last flag written
//   error        out  ROM address overflow or descriptor seen in DONE
// -----------------------------------------------------------------------------
module taglist_writer
   import taglist_pkg::*;
#(
   parameter int MAX_ENTRIES = 127
) (
   input  logic                 clock_n,
   input  logic                 reset,
   input  logic                 list_start,
   input  logic                 seg_valid,
   output logic                 seg_ready,
   input  logic [ROM_AW-1:0]    seg_len,
   input  logic                 seg_last,
   output logic                 taglist_wr,
   output logic [TAG_W-1:0]     taglist_addr,
   output logic [ENTRY_W-1:0]   taglist_data,
   output logic [7:0]           entry_count,
   output logic                 done,
   output logic                 error
);

   state_t               state_q, state_d;

   logic [7:0]           index_q, index_d;
   logic [ROM_AW:0]      base_q,  base_d;     // 11 bits: may reach 1024
   logic [ROM_AW-1:0]    end_q,   end_d;
   logic                 last_q,  last_d;
   logic [7:0]           count_q, count_d;
   logic [TAG_W-1:0]     addr_q,  addr_d;
   logic [ENTRY_W-1:0]   data_q,  data_d;

   logic [ROM_AW:0]      sum_w;
   logic                 ovf_w;
   logic                 last_w;
   logic                 accept_w;
   logic [ENTRY_W-1:0]   entry_w;

   // End address of the offered segment; bit 10 set means it does not fit
   // in ROM space (this also catches base already at 1024).
   assign sum_w    = base_q + {1'b0, seg_len};
   assign ovf_w    = sum_w[ROM_AW];
   // The final slot of the RAM always closes the list.
   assign last_w   = seg_last | (index_q == 8'(MAX_ENTRIES - 1));
   assign accept_w = (state_q == ST_READY) && seg_valid;

   always_comb begin
      entry_w                         = '0;
      entry_w[TAG_LSB   +: TAG_W]     = index_q[TAG_W-1:0] + 7'd1;
      entry_w[START_LSB +: START_W]   = base_q[ROM_AW-1:0];
      entry_w[END_LSB   +: END_W]     = sum_w[ROM_AW-1:0];
      entry_w[LAST_BIT]               = last_w;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock_n or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (list_start) begin
         state_d = ST_READY;
      end else begin
         unique case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_READY: if (seg_valid) state_d = ovf_w ? ST_ERR : ST_WRITE;
            ST_WRITE: state_d = last_q ? ST_DONE : ST_READY;
            ST_DONE:  if (seg_valid) state_d = ST_ERR;
            ST_ERR:   state_d = ST_ERR;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      seg_ready  = (state_q == ST_READY);
      taglist_wr = (state_q == ST_WRITE);
      done       = (state_q == ST_DONE);
      error      = (state_q == ST_ERR);
   end

   // ---------------- datapath next state ----------------
   // The entry is registered on the handshake edge, so address and data are
   // valid during the WRITE cycle and then simply held.
   always_comb begin
      index_d = index_q;
      base_d  = base_q;
      end_d   = end_q;
      last_d  = last_q;
      count_d = count_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (list_start) begin
         index_d = '0;
         base_d  = '0;
         count_d = '0;
      end else begin
         if (accept_w && !ovf_w) begin
            end_d  = sum_w[ROM_AW-1:0];
            last_d = last_w;
            addr_d = index_q[TAG_W-1:0];
            data_d = entry_w;
         end
         if (state_q == ST_WRITE) begin
            index_d = index_q + 8'd1;
            count_d = index_q + 8'd1;
            base_d  = {1'b0, end_q} + 11'd1;
         end
      end
   end

   always_ff @(posedge clock_n or posedge reset) begin
      if (reset) begin
         index_q <= '0;
         base_q  <= '0;
         end_q   <= '0;
         last_q  <= 1'b0;
         count_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         index_q <= index_d;
         base_q  <= base_d;
         end_q   <= end_d;
         last_q  <= last_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign taglist_addr = addr_q;
   assign taglist_data = data_q;
   assign entry_count  = count_q;

endmodule

// File: tb/tb_taglist_writer.sv
module tb_taglist_writer;

   logic        clock_n = 1'b0;
   logic        reset = 1'b1;
   logic        list_start = 1'b0;
   logic        seg_valid = 1'b0;
   logic        seg_ready;
   logic [9:0]  seg_len = '0;
   logic        seg_last = 1'b0;
   logic        taglist_wr;
   logic [6:0]  taglist_addr;
   logic [31:0] taglist_data;
   logic [7:0]  entry_count;
   logic        done;
   logic        error;

   int nerr = 0;
   int nchk = 0;
   int cyc  = 0;

   // captured RAM writes
   int          waddr[$];
   logic [31:0] wdata[$];
   int          wcyc[$];

   // descriptors offered in the current list, and the expected entries
   int          lens_q[$];
   bit          lasts_q[$];
   logic [31:0] exp_q[$];

   taglist_writer #(.MAX_ENTRIES(127)) dut (
      .clock_n(clock_n), .reset(reset), .list_start(list_start),
      .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_len(seg_len),
      .seg_last(seg_last), .taglist_wr(taglist_wr), .taglist_addr(taglist_addr),
      .taglist_data(taglist_data), .entry_count(entry_count), .done(done),
      .error(error)
   );

   always #5 clock_n = ~clock_n;
   always @(posedge clock_n) cyc++;

   always @(negedge clock_n) begin
      if (taglist_wr === 1'b1) begin
         waddr.push_back(int'(taglist_addr));
         wdata.push_back(taglist_data);
         wcyc.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: segments tile ROM space from 0; an entry whose end would pass
   // 1023 is never written; the 127th entry always carries last.
   function automatic void build_exp();
      int base = 0;
      int e;
      bit l;
      exp_q.delete();
      for (int i = 0; i < lens_q.size(); i++) begin
         e = base + lens_q[i];
         if (base > 1023 || e > 1023) break;
         l = lasts_q[i] || (i == 126);
         exp_q.push_back(32'(((i + 1) << 21) | (base << 11) | (e << 1) | int'(l)));
         base = e + 1;
         if (l) break;
      end
   endfunction

   task automatic check_list(input string tag);
      build_exp();
      chk({tag, "_nwrites"}, 32'(wdata.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wdata.size(); i++) begin
         chk($sformatf("%s_addr%0d", tag, i), 32'(waddr[i]), 32'(i));
         chk($sformatf("%s_data%0d", tag, i), wdata[i], exp_q[i]);
      end
   endtask

   task automatic clear_model();
      waddr.delete(); wdata.delete(); wcyc.delete();
      lens_q.delete(); lasts_q.delete();
   endtask

   task automatic start_list();
      @(negedge clock_n);
      @(posedge clock_n); #1;
      list_start = 1'b1;
      clear_model();
      @(posedge clock_n); #1;
      list_start = 1'b0;
   endtask

   task automatic send(input logic [9:0] len, input bit last, input bit expwr);
      bit got = 0;
      seg_valid = 1'b1; seg_len = len; seg_last = last;
      lens_q.push_back(int'(len)); lasts_q.push_back(last);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock_n);
         if (seg_ready === 1'b1) got = 1;
      end
      chk("handshake", 32'(got), 32'd1);
      @(posedge clock_n); #1;
      seg_valid = 1'b0;
      chk("wr_latency", 32'(taglist_wr), 32'(expwr));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock_n);
      #1;
   endtask

   initial begin
      int n;
      bit got;

      // ---- reset state ----
      #2;
      chk("rst_ready", 32'(seg_ready), 0);
      chk("rst_wr",    32'(taglist_wr), 0);
      chk("rst_addr",  32'(taglist_addr), 0);
      chk("rst_data",  taglist_data, 0);
      chk("rst_count", 32'(entry_count), 0);
      chk("rst_done",  32'(done), 0);
      chk("rst_error", 32'(error), 0);
      idle(2);
      reset = 1'b0;
      idle(3);
      chk("idle_ready", 32'(seg_ready), 0);

      // ---- five-segment list ----
      start_list();
      chk("l1_ready", 32'(seg_ready), 1);
      send(10'd5, 0, 1); send(10'd6, 0, 1); send(10'd8, 0, 1);
      send(10'd20, 0, 1); send(10'd20, 1, 1);
      idle(2);
      check_list("l1");
      if (wdata.size() == 5) chk("l1_e4_const", wdata[4], 32'h00A1587F);
      chk("l1_done",  32'(done), 1);
      chk("l1_count", 32'(entry_count), 5);
      chk("l1_ready_done", 32'(seg_ready), 0);
      chk("l1_wr_off", 32'(taglist_wr), 0);
      chk("l1_hold_data", taglist_data, 32'h00A1587F);
      // descriptor while DONE
      seg_valid = 1'b1; idle(1); seg_valid = 1'b0; idle(1);
      chk("done_valid_err", 32'(error), 1);
      chk("done_valid_done", 32'(done), 0);

      // ---- ROM overflow ----
      start_list();
      chk("ovf_clr_err", 32'(error), 0);
      chk("ovf_clr_cnt", 32'(entry_count), 0);
      send(10'd1023, 0, 1);
      send(10'd0, 0, 0);
      idle(2);
      check_list("ovf");
      if (wdata.size() >= 1) chk("ovf_e0_const", wdata[0], 32'h002007FE);
      chk("ovf_error", 32'(error), 1);
      chk("ovf_ready", 32'(seg_ready), 0);
      chk("ovf_count", 32'(entry_count), 1);

      // ---- full RAM: 127 zero-length segments ----
      start_list();
      for (int i = 0; i < 127; i++) send(10'd0, 0, 1);
      idle(2);
      check_list("full");
      if (wdata.size() == 127) chk("full_e126_const", wdata[126], 32'h0FE3F0FD);
      chk("full_done",  32'(done), 1);
      chk("full_count", 32'(entry_count), 127);

      // ---- list_start during WRITE: the write still goes out ----
      start_list();
      send(10'd7, 0, 1);
      list_start = 1'b1;
      @(posedge clock_n); #1;
      list_start = 1'b0;
      chk("lsw_nwrites", 32'(wdata.size()), 1);
      if (wdata.size() == 1) chk("lsw_data", wdata[0], 32'h0020000E);
      chk("lsw_count", 32'(entry_count), 0);
      chk("lsw_ready", 32'(seg_ready), 1);

      // ---- restart after two entries ----
      start_list();
      send(10'd10, 0, 1); send(10'd10, 0, 1);
      start_list();
      send(10'd3, 1, 1);
      idle(2);
      check_list("rst2");
      if (wdata.size() == 1) chk("rst2_const", wdata[0], 32'h00200007);
      chk("rst2_count", 32'(entry_count), 1);
      chk("rst2_done", 32'(done), 1);

      // ---- reset in the middle of a WRITE ----
      start_list();
      send(10'd4, 0, 1); send(10'd4, 0, 1);
      send(10'd4, 0, 1);                    // returns inside WRITE
      reset = 1'b1; #1;
      chk("mr_wr",    32'(taglist_wr), 0);
      chk("mr_ready", 32'(seg_ready), 0);
      chk("mr_addr",  32'(taglist_addr), 0);
      chk("mr_data",  taglist_data, 0);
      chk("mr_count", 32'(entry_count), 0);
      chk("mr_done",  32'(done), 0);
      chk("mr_error", 32'(error), 0);
      idle(1);
      reset = 1'b0;
      got = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock_n);
         if (seg_ready !== 1'b0) got = 1;
      end
      chk("mr_ready_stays0", 32'(got), 0);
      start_list();
      chk("mr_ready_after_start", 32'(seg_ready), 1);

      // ---- back-to-back with seg_valid held high ----
      for (int rep = 0; rep < 3; rep++) begin
         start_list();
         n = int'($urandom_range(4, 10));
         seg_valid = 1'b1;
         for (int k = 0; k < n; k++) begin
            seg_len  = 10'($urandom_range(0, 90));
            seg_last = (k == n - 1);
            lens_q.push_back(int'(seg_len)); lasts_q.push_back(seg_last);
            got = 0;
            for (int i = 0; i < 10 && !got; i++) begin
               @(negedge clock_n);
               if (seg_ready === 1'b1) got = 1;
            end
            chk("b2b_handshake", 32'(got), 1);
            @(posedge clock_n); #1;
         end
         seg_valid = 1'b0;
         idle(2);
         check_list($sformatf("b2b%0d", rep));
         for (int i = 1; i < wcyc.size(); i++)
            chk("b2b_spacing", 32'(wcyc[i] - wcyc[i-1]), 2);
         chk("b2b_count", 32'(entry_count), 32'(n));
         chk("b2b_done",  32'(done), 1);
      end

      // ---- random lists with gaps between descriptors ----
      for (int rep = 0; rep < 3; rep++) begin
         start_list();
         n = int'($urandom_range(1, 10));
         for (int k = 0; k < n; k++) begin
            idle(int'($urandom_range(0, 3)));
            send(10'($urandom_range(0, 90)), (k == n - 1), 1);
         end
         idle(2);
         check_list($sformatf("rnd%0d", rep));
         chk("rnd_count", 32'(entry_count), 32'(n));
         chk("rnd_done",  32'(done), 1);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
